key_debounce_multi: RTL and testbench



---
 rtl/key_pkg.sv | 27 ++
 rtl/key_debounce_ch.sv | 116 +++++++++++
 rtl/key_debounce_multi.sv | 40 ++++
 tb/tb_key_debounce_multi.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer family: FSM encoding, default timing
// constants and the per-channel event bundle.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        PRESS_DEB   = 2'b01,
        HELD        = 2'b10,
        RELEASE_DEB = 2'b11
    } key_state_e;

    localparam int unsigned DEB_20MS_50M = 32'd1_000_000;
    localparam int unsigned LONG_1S_50M  = 32'd50_000_000;

    typedef struct packed {
        logic level;
        logic press;
        logic rls;
        logic hold_long;
    } key_evt_t;

    // Counter width able to hold values up to num_states-1, never below one bit.
    function automatic int unsigned cnt_width(input int unsigned num_states);
        return (num_states > 32'd1) ? 32'($clog2(num_states)) : 32'd1;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, polarity normalisation, debounce FSM
// with stability counter and a saturating hold counter for long-press detection.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = DEB_20MS_50M,
    parameter int unsigned LONG_CYCLES = LONG_1S_50M,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     key_raw,
    output key_evt_t evt
);

    localparam int unsigned       DEB_W     = cnt_width(DEB_CYCLES);
    localparam int unsigned       HOLD_W    = cnt_width(LONG_CYCLES + 32'd1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 32'd1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 32'd1);
    localparam bit                LONG_EN   = (LONG_CYCLES != 32'd0);

    logic              sync1;
    logic              sync2;
    logic              pressed_c;
    key_state_e        state;
    key_state_e        state_nxt;
    logic [DEB_W-1:0]  deb_cnt;
    logic [DEB_W-1:0]  deb_cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    key_evt_t          evt_nxt;

    // Synchroniser presets to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    assign pressed_c = sync2 ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            deb_cnt  <= '0;
            hold_cnt <= '0;
            evt      <= '0;
        end else begin
            state    <= state_nxt;
            deb_cnt  <= deb_cnt_nxt;
            hold_cnt <= hold_cnt_nxt;
            evt      <= evt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        deb_cnt_nxt   = deb_cnt;
        hold_cnt_nxt  = hold_cnt;
        evt_nxt       = '0;
        evt_nxt.level = evt.level;

        // Hold time keeps running through release bounce so a long press still completes.
        if ((state == HELD) || (state == RELEASE_DEB)) begin
            if (hold_cnt != HOLD_MAX) begin
                hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            end
            evt_nxt.hold_long = LONG_EN && (hold_cnt == HOLD_FIRE);
        end

        case (state)
            IDLE: begin
                if (pressed_c) begin
                    state_nxt   = PRESS_DEB;
                    deb_cnt_nxt = '0;
                end
            end
            PRESS_DEB: begin
                if (!pressed_c) begin
                    state_nxt = IDLE;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt     = HELD;
                    evt_nxt.press = 1'b1;
                    evt_nxt.level = 1'b1;
                    hold_cnt_nxt  = '0;
                end else begin
                    deb_cnt_nxt = deb_cnt + DEB_W'(1);
                end
            end
            HELD: begin
                if (!pressed_c) begin
                    state_nxt   = RELEASE_DEB;
                    deb_cnt_nxt = '0;
                end
            end
            RELEASE_DEB: begin
                if (pressed_c) begin
                    state_nxt = HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt     = IDLE;
                    evt_nxt.rls   = 1'b1;
                    evt_nxt.level = 1'b0;
                end else begin
                    deb_cnt_nxt = deb_cnt + DEB_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: NUM_KEYS independent channels, each reporting a
// debounced level and one-cycle press, release and long-press pulses.
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS    = 4,
    parameter int unsigned DEB_CYCLES  = DEB_20MS_50M,
    parameter int unsigned LONG_CYCLES = LONG_1S_50M,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_evt_t evt;

        key_debounce_ch #(
            .DEB_CYCLES  (DEB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .key_raw (key_in[i]),
            .evt     (evt)
        );

        assign key_level[i]   = evt.level;
        assign key_press[i]   = evt.press;
        assign key_release[i] = evt.rls;
        assign key_long[i]    = evt.hold_long;
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: vector table, hand-written corner sequences and
// random stimulus checked against a streak-counting reference model.
module tb_key_debounce_multi;
    import key_pkg::*;

    localparam int unsigned NK   = 2;
    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 10;

    logic          clk;
    logic          rst_n;
    logic [NK-1:0] key_in;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_long;

    key_debounce_multi #(
        .NUM_KEYS    (NK),
        .DEB_CYCLES  (DEB),
        .LONG_CYCLES (LONG),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a transition is accepted once the pressed level seen two samples
    // late has disagreed with the accepted level for DEB+1 consecutive edges.
    bit       d1 [NK];
    bit       d2 [NK];
    bit       lvl[NK];
    int       run[NK];
    int       age[NK];
    logic [1:0] m_level, m_press, m_rel, m_long;

    task automatic model_reset();
        for (int c = 0; c < NK; c++) begin
            d1[c] = 1'b0; d2[c] = 1'b0; lvl[c] = 1'b0; run[c] = 0; age[c] = 0;
        end
        m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
    endtask

    task automatic model_edge();
        m_press = '0; m_rel = '0; m_long = '0;
        for (int c = 0; c < NK; c++) begin
            bit p;
            p     = d2[c];
            d2[c] = d1[c];
            d1[c] = ~key_in[c];
            if (lvl[c] && age[c] < LONG) begin
                age[c]++;
                if (age[c] == LONG) m_long[c] = 1'b1;
            end
            if (p != lvl[c]) begin
                run[c]++;
                if (run[c] == DEB + 1) begin
                    lvl[c] = ~lvl[c];
                    run[c] = 0;
                    if (lvl[c]) begin
                        m_press[c] = 1'b1;
                        age[c]     = 0;
                    end else begin
                        m_rel[c] = 1'b1;
                    end
                end
            end else begin
                run[c] = 0;
            end
            m_level[c] = lvl[c];
        end
    endtask

    task automatic tick(input logic [1:0] kin);
        key_in = kin;
        @(posedge clk);
        model_edge();
        #1;
        chk2("model_level",   key_level,   m_level);
        chk2("model_press",   key_press,   m_press);
        chk2("model_release", key_release, m_rel);
        chk2("model_long",    key_long,    m_long);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(2'b11);
    endtask

    typedef struct {
        logic [1:0] kin;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
        logic [1:0] lng;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic [1:0] kin, input logic [1:0] lv,
                                    input logic [1:0] pr, input logic [1:0] rl,
                                    input logic [1:0] lg);
        vec_t v;
        v.kin = kin; v.lvl = lv; v.prs = pr; v.rel = rl; v.lng = lg;
        vecs.push_back(v);
    endfunction

    int press_cnt, rel_cnt, long_cnt, press_at, rel_at, long_at;
    logic [1:0] r;

    initial begin
        rst_n  = 1'b0;
        key_in = 2'b11;
        model_reset();

        // Clean press/release on key 0, then both keys together.
        for (int i = 0; i < 6; i++) add_vec(2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        add_vec(2'b10, 2'b01, 2'b01, 2'b00, 2'b00);
        add_vec(2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 6; i++) add_vec(2'b11, 2'b01, 2'b00, 2'b00, 2'b00);
        add_vec(2'b11, 2'b00, 2'b00, 2'b01, 2'b00);
        add_vec(2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 6; i++) add_vec(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_vec(2'b00, 2'b11, 2'b11, 2'b00, 2'b00);
        add_vec(2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 6; i++) add_vec(2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        add_vec(2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
        add_vec(2'b11, 2'b00, 2'b00, 2'b00, 2'b00);

        repeat (2) @(posedge clk);
        #1;
        chk2("rst_level",   key_level,   2'b00);
        chk2("rst_press",   key_press,   2'b00);
        chk2("rst_release", key_release, 2'b00);
        chk2("rst_long",    key_long,    2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].kin);
            chk2($sformatf("tbl%0d_level", i),   key_level,   vecs[i].lvl);
            chk2($sformatf("tbl%0d_press", i),   key_press,   vecs[i].prs);
            chk2($sformatf("tbl%0d_release", i), key_release, vecs[i].rel);
            chk2($sformatf("tbl%0d_long", i),    key_long,    vecs[i].lng);
        end
        idle(4);

        // Bounce shorter than the window is rejected.
        press_cnt = 0; long_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            tick(((i / 2) % 2 == 0 && i < 8) ? 2'b10 : 2'b11);
            if (key_press[0]) press_cnt++;
            if (key_level[0]) long_cnt++;
        end
        chki("bounce_press_cnt", press_cnt, 0);
        chki("bounce_level_hi_cycles", long_cnt, 0);
        chki("bounce_state", int'(dut.g_ch[0].u_ch.state), int'(IDLE));

        // Release glitch rejected; long press completes during release debounce.
        press_cnt = 0; rel_cnt = 0; long_cnt = 0; rel_at = -1;
        for (int i = 0; i < 8; i++) begin
            tick(2'b10);
            if (key_long[0]) long_cnt++;
        end
        chk2("glitch_held_level", key_level, 2'b01);
        tick(2'b11); tick(2'b11); tick(2'b10);
        if (key_long[0]) long_cnt++;
        for (int k = 0; k < 12; k++) begin
            tick(2'b11);
            if (key_press[0]) press_cnt++;
            if (key_long[0]) long_cnt++;
            if (key_release[0]) begin
                rel_cnt++;
                rel_at = k;
            end
        end
        chki("glitch_press_cnt", press_cnt, 0);
        chki("glitch_release_cnt", rel_cnt, 1);
        chki("glitch_release_at", rel_at, 6);
        chki("glitch_long_cnt", long_cnt, 1);
        idle(4);

        // Long hold on key 1.
        press_cnt = 0; long_cnt = 0; press_at = -1; long_at = -1;
        for (int k = 0; k < 30; k++) begin
            tick(2'b01);
            if (key_press[1]) begin press_cnt++; press_at = k; end
            if (key_long[1])  begin long_cnt++;  long_at  = k; end
        end
        chki("long_press_cnt", press_cnt, 1);
        chki("long_press_at", press_at, 6);
        chki("long_cnt", long_cnt, 1);
        chki("long_delay", long_at - press_at, 10);
        idle(10);
        chk2("long_released_level", key_level, 2'b00);

        // Long pulse coincides with release acceptance.
        rel_at = -1; long_at = -1;
        for (int k = 0; k < 10; k++) tick(2'b10);
        for (int k = 0; k < 10; k++) begin
            tick(2'b11);
            if (key_release[0]) rel_at = k;
            if (key_long[0])    long_at = k;
        end
        chki("coincide_release_at", rel_at, 6);
        chki("coincide_long_at", long_at, 6);
        idle(3);

        // Asynchronous reset while held, then a fresh press after reset.
        for (int k = 0; k < 8; k++) tick(2'b10);
        chk2("prerst_level", key_level, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        chk2("async_rst_level",   key_level,   2'b00);
        chk2("async_rst_press",   key_press,   2'b00);
        chk2("async_rst_release", key_release, 2'b00);
        chk2("async_rst_long",    key_long,    2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        press_at = -1; press_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick(2'b10);
            if (key_press[0]) begin press_cnt++; press_at = k; end
        end
        chki("postrst_press_at", press_at, 6);
        chki("postrst_press_cnt", press_cnt, 1);
        idle(10);

        // Random key activity against the reference model.
        r = 2'b11;
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < NK; c++) begin
                if ($urandom_range(0, 6) == 0) r[c] = ~r[c];
            end
            tick(r);
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
